// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX arbiter and the TX/RX datapaths.
//   arb_state_e : arbiter FSM states
//   DATA_W      : UART byte width
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle between N_REQ byte producers / the TX serializer
// and the arbiter.
//   req, req_data      producer requests and bytes (8 bits per requester)
//   ack                one-cycle per-requester acceptance pulse
//   tx_start, tx_data  launch pulse and byte toward the serializer
//   tx_busy            serializer busy flag
//   grant_valid/_id    current grant status
//   tx_timeout         serializer never went busy
// modport master: arbiter side; modport slave: producers + serializer side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [DATA_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    grant_valid;
  logic [IDW-1:0]          grant_id;
  logic                    tx_timeout;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_start, tx_data, grant_valid, grant_id, tx_timeout
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_start, tx_data, grant_valid, grant_id, tx_timeout
  );

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector.
//   req_i    : request vector
//   rr_ptr_i : highest-priority index
//   found_o  : any request set
//   idx_o    : first set bit at or after rr_ptr_i, wrapping modulo N_REQ
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   rr_ptr_i,
  output logic             found_o,
  output logic [IDW-1:0]   idx_o
);

  logic           found_hi, found_lo;
  logic [IDW-1:0] idx_hi, idx_lo;

  // Lowest set bit at/above the pointer wins; otherwise the lowest set bit
  // overall (the wrapped-around candidate). Indices never exceed N_REQ-1.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (req_i[j] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IDW'(j);
      end
      if (req_i[j] && !found_hi && (IDW'(j) >= rr_ptr_i)) begin
        found_hi = 1'b1;
        idx_hi   = IDW'(j);
      end
    end
    found_o = found_lo;
    idx_o   = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte producers.
// Round-robin grant with bursts capped at MAX_BURST bytes, a one-cycle launch
// pulse per byte, and a timeout when tx_busy fails to rise.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.master (requests, acks, TX launch, status)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);

  localparam int IDW = $clog2(N_REQ);
  // The LAUNCH cycle already counts toward the budget, so the timeout fires
  // on the (BUSY_TIMEOUT-1)th WAIT_BUSY increment to land exactly
  // BUSY_TIMEOUT cycles after tx_start.
  localparam logic [7:0] TMO_LAST = (BUSY_TIMEOUT > 1) ? 8'(BUSY_TIMEOUT - 1) : 8'd1;

  arb_state_e        state_q;
  logic [IDW-1:0]    rr_ptr_q, grant_id_q;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [N_REQ-1:0]  ack_q;
  logic              tx_start_q, grant_valid_q, tx_timeout_q;
  logic [DATA_W-1:0] tx_data_q;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx, sel_id, rr_next;
  logic [DATA_W-1:0] sel_byte;
  logic [N_REQ-1:0]  sel_onehot;
  logic              req_gnt;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  // In IDLE the launch targets the fresh pick; otherwise a burst relaunch
  // targets the current grant.
  always_comb begin
    sel_id     = (state_q == IDLE) ? pick_idx : grant_id_q;
    sel_byte   = '0;
    sel_onehot = '0;
    req_gnt    = 1'b0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (IDW'(j) == sel_id) begin
        sel_byte      = bus.req_data[DATA_W*j +: DATA_W];
        sel_onehot[j] = 1'b1;
      end
      if (IDW'(j) == grant_id_q) begin
        req_gnt = bus.req[j];
      end
    end
    rr_next     = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    burst_cnt_d = burst_cnt_q + 4'd1;
    tmo_cnt_d   = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      burst_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      ack_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_valid_q <= 1'b0;
      tx_timeout_q  <= 1'b0;
    end else begin
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q    <= pick_idx;
            ack_q         <= sel_onehot;
            tx_start_q    <= 1'b1;
            tx_data_q     <= sel_byte;
            grant_valid_q <= 1'b1;
            state_q       <= LAUNCH;
          end
        end
        LAUNCH: begin
          burst_cnt_q <= burst_cnt_d;
          tmo_cnt_q   <= '0;
          state_q     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_d == TMO_LAST) begin
              burst_cnt_q   <= '0;
              rr_ptr_q      <= rr_next;
              grant_valid_q <= 1'b0;
              tx_timeout_q  <= 1'b1;
              state_q       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (req_gnt && (burst_cnt_q < 4'(MAX_BURST))) begin
              ack_q      <= sel_onehot;
              tx_start_q <= 1'b1;
              tx_data_q  <= sel_byte;
              state_q    <= LAUNCH;
            end else begin
              burst_cnt_q   <= '0;
              rr_ptr_q      <= rr_next;
              grant_valid_q <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.tx_timeout  = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (N_REQ=4/MAX_BURST=4 and
// N_REQ=3/MAX_BURST=1), a behavioural tx_busy responder per instance, and a
// scoreboard of expected grants checked on every launch.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         gap;   // required cycles from last busy fall to this start; 0 = unchecked
  } exp_t;

  localparam int BLEN_A = 20;
  localparam int BLEN_B = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   fall_a  = 0;
  int   fall_b  = 0;
  int   start_a = 0;
  bit   dead_a  = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] da [4] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
  logic [7:0] db [3] = '{8'h10, 8'h21, 8'h32};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N_REQ(4)) ifa ();
  uart_tx_arbiter_if #(.N_REQ(3)) ifb ();

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .BUSY_TIMEOUT(15)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  uart_tx_arbiter #(.N_REQ(3), .MAX_BURST(1), .BUSY_TIMEOUT(15)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [7:0] d, input int gap);
    exp_t r;
    r.id   = id;
    r.data = d;
    r.gap  = gap;
    return r;
  endfunction

  task automatic wait_idle_a(input int budget, input string tag);
    int n = 0;
    while (ifa.grant_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, ifa.grant_valid, 1'b0);
  endtask

  task automatic wait_idle_b(input int budget, input string tag);
    int n = 0;
    while (ifb.grant_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, ifb.grant_valid, 1'b0);
  endtask

  task automatic wait_q_a(input int budget, input string tag);
    int n = 0;
    while (qa.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, qa.size(), 0);
  endtask

  task automatic wait_q_b(input int budget, input string tag);
    int n = 0;
    while (qb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, qb.size(), 0);
  endtask

  // Transmitter models: busy rises the cycle after a launch is seen and stays
  // high for BLEN cycles. dead_a keeps instance A's transmitter silent.
  initial begin
    ifa.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.tx_start && !dead_a) begin
        @(negedge clk);
        ifa.tx_busy = 1'b1;
        repeat (BLEN_A) @(negedge clk);
        ifa.tx_busy = 1'b0;
        fall_a = cyc;
      end
    end
  end

  initial begin
    ifb.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.tx_start) begin
        @(negedge clk);
        ifb.tx_busy = 1'b1;
        repeat (BLEN_B) @(negedge clk);
        ifb.tx_busy = 1'b0;
        fall_b = cyc;
      end
    end
  end

  // Scoreboard monitors: every launch (or stray ack) consumes one expectation.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset && (ifa.tx_start || ifa.ack != '0)) begin
      check_eq("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check_eq("a_grant_id", ifa.grant_id, e.id);
        check_eq("a_tx_data", ifa.tx_data, e.data);
        check_eq("a_ack_start", {ifa.tx_start, ifa.grant_valid, ifa.ack},
                 {1'b1, 1'b1, 4'(1 << e.id)});
        if (e.gap != 0) check_eq("a_gap", cyc - fall_a, e.gap);
      end
      start_a = cyc;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset && (ifb.tx_start || ifb.ack != '0)) begin
      check_eq("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
      check_eq("b_gid_range", 64'(ifb.grant_id < 2'd3), 64'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check_eq("b_grant_id", ifb.grant_id, e.id);
        check_eq("b_tx_data", ifb.tx_data, e.data);
        check_eq("b_ack_start", {ifb.tx_start, ifb.grant_valid, ifb.ack},
                 {1'b1, 1'b1, 3'(1 << e.id)});
        if (e.gap != 0) check_eq("b_gap", cyc - fall_b, e.gap);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $fatal(1);
  end

  initial begin
    int n;
    ifa.req      = '0;
    ifa.req_data = {da[3], da[2], da[1], da[0]};
    ifb.req      = '0;
    ifb.req_data = {db[2], db[1], db[0]};
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_a", {ifa.ack, ifa.tx_start, ifa.tx_data, ifa.grant_valid,
                       ifa.grant_id, ifa.tx_timeout}, '0);
    check_eq("rst_b", {ifb.ack, ifb.tx_start, ifb.tx_data, ifb.grant_valid,
                       ifb.grant_id, ifb.tx_timeout}, '0);
    reset = 1'b1;
    @(negedge clk);

    // Single request, one-cycle latency, return to idle the cycle after busy falls.
    qa.push_back(mk(0, da[0], 0));
    ifa.req = 4'b0001;
    @(negedge clk);
    check_eq("s1_latency", {ifa.tx_start, ifa.ack}, {1'b1, 4'b0001});
    ifa.req = '0;
    wait_idle_a(60, "s1_idle");
    check_eq("s1_idle_at_fall", cyc - fall_a, 1);
    check_eq("s1_gid_hold", ifa.grant_id, 0);
    check_eq("s1_data_hold", ifa.tx_data, da[0]);

    // Burst cap: rr_ptr=1, requesters 2 and 3 held -> 4 bytes from 2, then 3.
    qa.push_back(mk(2, da[2], 0));
    qa.push_back(mk(2, da[2], 1));
    qa.push_back(mk(2, da[2], 1));
    qa.push_back(mk(2, da[2], 1));
    qa.push_back(mk(3, da[3], 2));
    ifa.req = 4'b1100;
    wait_q_a(400, "s2_drain");
    ifa.req = '0;
    wait_idle_a(60, "s2_idle");

    // Timeout with a dead transmitter; rr_ptr then moves past requester 1.
    dead_a = 1'b1;
    qa.push_back(mk(1, da[1], 0));
    ifa.req = 4'b0010;
    @(negedge clk);
    ifa.req = '0;
    n = 0;
    while (!ifa.tx_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("s4_tmo_seen", ifa.tx_timeout, 1'b1);
    check_eq("s4_tmo_delay", cyc - start_a, 15);
    check_eq("s4_gv_drop", ifa.grant_valid, 1'b0);
    @(negedge clk);
    check_eq("s4_tmo_pulse", ifa.tx_timeout, 1'b0);
    dead_a = 1'b0;
    qa.push_back(mk(2, da[2], 0));
    ifa.req = 4'b0110;
    wait_q_a(10, "s4_next");
    ifa.req = '0;
    wait_idle_a(60, "s4_idle");

    // N_REQ=3, MAX_BURST=1: strict rotation with wrap 2 -> 0.
    qb.push_back(mk(0, db[0], 0));
    qb.push_back(mk(1, db[1], 2));
    qb.push_back(mk(2, db[2], 2));
    qb.push_back(mk(0, db[0], 2));
    qb.push_back(mk(1, db[1], 2));
    ifb.req = 3'b111;
    wait_q_b(200, "b_rr");
    ifb.req = '0;
    wait_idle_b(30, "b_rr_idle");
    qb.push_back(mk(2, db[2], 0));
    qb.push_back(mk(0, db[0], 2));
    ifb.req = 3'b101;
    wait_q_b(60, "b_wrap");
    ifb.req = '0;
    wait_idle_b(30, "b_wrap_idle");

    // Reset mid-frame on A (rr_ptr=3), then a fresh request from rr_ptr=0.
    qa.push_back(mk(3, da[3], 0));
    ifa.req = 4'b1000;
    @(negedge clk);
    ifa.req = '0;
    n = 0;
    while (!ifa.tx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("s5_in_frame", ifa.grant_valid, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("s5_rst_out", {ifa.ack, ifa.tx_start, ifa.tx_data, ifa.grant_valid,
                            ifa.grant_id, ifa.tx_timeout}, '0);
    n = 0;
    while (ifa.tx_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    qa.push_back(mk(0, da[0], 0));
    ifa.req = 4'b1001;
    @(negedge clk);
    check_eq("s5_latency", ifa.tx_start, 1'b1);
    ifa.req = '0;
    wait_idle_a(60, "s5_idle");

    check_eq("a_sb_left", qa.size(), 0);
    check_eq("b_sb_left", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
